// File: rtl/mu0_pkg.sv
// Shared constants and control-word type for the MU0 control unit.
package mu0_pkg;

    localparam logic [1:0] FETCH = 2'b00;
    localparam logic [1:0] EXEC  = 2'b01;
    localparam logic [1:0] HALT  = 2'b10;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] ALU_Y   = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_INC = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef struct packed {
        logic       x_sel;
        logic       y_sel;
        logic       addr_sel;
        logic       pc_en;
        logic       ir_en;
        logic       acc_en;
        logic [1:0] m;
        logic       rd;
        logic       wr;
    } ctrl_t;

endpackage

// File: rtl/mu0_decode.sv
// Combinational EXEC-phase decode: datapath control word plus exit/halt flags.
import mu0_pkg::*;

module mu0_decode #(
    parameter int unsigned HALT_ON_ILLEGAL = 0
) (
    input  logic [3:0] f,
    input  logic       n,
    input  logic       z,
    input  logic       mem_ack,
    output ctrl_t      ctrl,
    output logic       exec_done,
    output logic       go_halt
);

    always_comb begin
        ctrl      = '0;
        exec_done = 1'b1;
        go_halt   = 1'b0;
        case (f)
            OP_LDA: begin
                ctrl.addr_sel = 1'b1;
                ctrl.rd       = 1'b1;
                ctrl.m        = ALU_Y;
                ctrl.acc_en   = mem_ack;
                exec_done     = mem_ack;
            end
            OP_STO: begin
                ctrl.addr_sel = 1'b1;
                ctrl.wr       = 1'b1;
                exec_done     = mem_ack;
            end
            OP_ADD, OP_SUB: begin
                ctrl.addr_sel = 1'b1;
                ctrl.rd       = 1'b1;
                ctrl.m        = (f == OP_SUB) ? ALU_SUB : ALU_ADD;
                ctrl.acc_en   = mem_ack;
                exec_done     = mem_ack;
            end
            OP_JMP, OP_JGE, OP_JNE: begin
                // Selects are driven for every jump; only the PC enable carries the condition.
                ctrl.y_sel = 1'b1;
                ctrl.m     = ALU_Y;
                ctrl.pc_en = (f == OP_JMP) || (f == OP_JGE && !n) || (f == OP_JNE && !z);
            end
            OP_STP:  go_halt = 1'b1;
            default: go_halt = (HALT_ON_ILLEGAL != 0);
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer with Rd/Wr + Mem_Ack wait states.
// Optional retired-instruction counter enabled by defining MU0_PERF_CNT_EN.
import mu0_pkg::*;

module mu0_control #(
    parameter int unsigned HALT_ON_ILLEGAL = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  F,
    input  logic        N,
    input  logic        Z,
    input  logic        Mem_Ack,
    output logic        X_sel,
    output logic        Y_sel,
    output logic        Addr_sel,
    output logic        PC_En,
    output logic        IR_En,
    output logic        Acc_En,
    output logic [1:0]  M,
    output logic        Rd,
    output logic        Wr,
    output logic        Halted,
    output logic [15:0] Instr_Count,
    output logic [1:0]  state_dbg
);

    // Handshake: Rd/Wr are the request (valid), Mem_Ack is the completion (ready).
    // A transfer completes in the cycle both are high; until then the request,
    // address select and ALU selects are held and no register enable fires.
    // Mem_Ack has no effect in cycles with neither Rd nor Wr asserted.

    logic [1:0] state, state_nxt;
    ctrl_t      exec_ctrl, ctrl;
    logic       exec_done, go_halt;

    mu0_decode #(.HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)) u_decode (
        .f         (F),
        .n         (N),
        .z         (Z),
        .mem_ack   (Mem_Ack),
        .ctrl      (exec_ctrl),
        .exec_done (exec_done),
        .go_halt   (go_halt)
    );

    always_comb begin
        ctrl      = '0;
        state_nxt = state;
        case (state)
            FETCH: begin
                ctrl.rd    = 1'b1;
                ctrl.x_sel = 1'b1;
                ctrl.m     = ALU_INC;
                ctrl.ir_en = Mem_Ack;
                ctrl.pc_en = Mem_Ack;
                if (Mem_Ack) state_nxt = EXEC;
            end
            EXEC: begin
                ctrl = exec_ctrl;
                if (go_halt)        state_nxt = HALT;
                else if (exec_done) state_nxt = FETCH;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
        // Reset gates outputs combinationally so a pending access is dropped at once.
        if (!Reset) ctrl = '0;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= FETCH;
        else        state <= state_nxt;
    end

    assign X_sel     = ctrl.x_sel;
    assign Y_sel     = ctrl.y_sel;
    assign Addr_sel  = ctrl.addr_sel;
    assign PC_En     = ctrl.pc_en;
    assign IR_En     = ctrl.ir_en;
    assign Acc_En    = ctrl.acc_en;
    assign M         = ctrl.m;
    assign Rd        = ctrl.rd;
    assign Wr        = ctrl.wr;
    assign Halted    = (state == HALT);
    assign state_dbg = state;

`ifdef MU0_PERF_CNT_EN
    logic [15:0] instr_count;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            instr_count <= 16'h0000;
        else if (state == EXEC && state_nxt != EXEC)
            instr_count <= instr_count + 16'd1;
    end

    assign Instr_Count = instr_count;
`else
    assign Instr_Count = 16'h0000;
`endif

endmodule
